// File: rtl/mant_align_pipe.sv
// mant_align_pipe: 3-stage lane-packed align / add / normalise pipeline.
// Optional sticky output: define MANT_ALIGN_PIPE_STICKY_EN.
module mant_align_pipe #(
  parameter int LANES  = 4,
  parameter int MANT_W = 14,
  parameter int EXP_W  = 5,
  parameter int G      = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES-1:0]              lane_en,
  input  logic [LANES-1:0]              sign_a,
  input  logic [LANES-1:0]              sign_b,
  input  logic [LANES*EXP_W-1:0]        exp_a,
  input  logic [LANES*EXP_W-1:0]        exp_b,
  input  logic [LANES*MANT_W-1:0]       mant_a,
  input  logic [LANES*MANT_W-1:0]       mant_b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES-1:0]              sign_o,
  output logic [LANES*(EXP_W+2)-1:0]    exp_o,
  output logic [LANES*(MANT_W+G)-1:0]   mant_o,
  output logic [LANES-1:0]              zero_o
`ifdef MANT_ALIGN_PIPE_STICKY_EN
  ,
  output logic [LANES-1:0]              sticky_o
`endif
);

  localparam int AW  = MANT_W + G;
  localparam int SW  = AW + 1;
  localparam int XW  = EXP_W + 2;
  localparam int LZW = $clog2(SW + 1);

  typedef struct packed {
    logic [AW-1:0]    big;
    logic [AW-1:0]    aln;
    logic [EXP_W-1:0] exp;
    logic             sign;
    logic             sub;
`ifdef MANT_ALIGN_PIPE_STICKY_EN
    logic             stk;
`endif
  } s1_t;

  typedef struct packed {
    logic [SW-1:0]    sum;
    logic [EXP_W-1:0] exp;
    logic             sign;
`ifdef MANT_ALIGN_PIPE_STICKY_EN
    logic             stk;
`endif
  } s2_t;

  typedef struct packed {
    logic [AW-1:0] mant;
    logic [XW-1:0] exp;
    logic          sign;
    logic          zero;
`ifdef MANT_ALIGN_PIPE_STICKY_EN
    logic          stk;
`endif
  } s3_t;

  function automatic s1_t align(
    input logic             en,
    input logic             sa,
    input logic             sb,
    input logic [EXP_W-1:0] ea,
    input logic [EXP_W-1:0] eb,
    input logic [MANT_W-1:0] ma,
    input logic [MANT_W-1:0] mb
  );
    s1_t              r;
    logic [EXP_W-1:0] d;
    logic [AW-1:0]    ext;
    r = '0;
    if (ea >= eb) begin
      d      = ea - eb;
      r.big  = {ma, {G{1'b0}}};
      ext    = {mb, {G{1'b0}}};
      r.exp  = ea;
      r.sign = sa;
    end else begin
      d      = eb - ea;
      r.big  = {mb, {G{1'b0}}};
      ext    = {ma, {G{1'b0}}};
      r.exp  = eb;
      r.sign = sb;
    end
    if (int'(d) >= AW) begin
      r.aln = '0;
`ifdef MANT_ALIGN_PIPE_STICKY_EN
      r.stk = |ext;
`endif
    end else begin
      r.aln = ext >> d;
`ifdef MANT_ALIGN_PIPE_STICKY_EN
      r.stk = |(ext & ((AW'(1) << d) - AW'(1)));
`endif
    end
    r.sub = sa ^ sb;
    if (!en) r = '0;
    return r;
  endfunction

  function automatic s2_t add(input s1_t s);
    s2_t           r;
    logic [SW-1:0] b;
    logic [SW-1:0] m;
    r      = '0;
    b      = {1'b0, s.big};
    m      = {1'b0, s.aln};
    r.exp  = s.exp;
    r.sign = s.sign;
    if (!s.sub) begin
      r.sum = b + m;
    end else if (m > b) begin
      r.sum  = m - b;
      r.sign = ~s.sign;
    end else begin
      r.sum = b - m;
    end
`ifdef MANT_ALIGN_PIPE_STICKY_EN
    r.stk = s.stk;
`endif
    return r;
  endfunction

  function automatic logic [LZW-1:0] lzc(input logic [SW-1:0] v);
    logic [LZW-1:0] r;
    r = LZW'(SW);
    for (int i = 0; i < SW; i++) begin
      if (v[i]) r = LZW'(SW - 1 - i);
    end
    return r;
  endfunction

  function automatic s3_t norm(input s2_t s);
    s3_t            r;
    logic [LZW-1:0] lz;
    logic [SW-1:0]  sh;
    r  = '0;
    lz = lzc(s.sum);
    sh = s.sum << lz;
    if (s.sum == '0) begin
      r.zero = 1'b1;
`ifdef MANT_ALIGN_PIPE_STICKY_EN
      r.stk  = s.stk;
`endif
    end else begin
      r.mant = sh[SW-1:1];
      r.exp  = XW'(s.exp) + XW'(1) - XW'(lz);
      r.sign = s.sign;
`ifdef MANT_ALIGN_PIPE_STICKY_EN
      r.stk  = s.stk | sh[0];
`endif
    end
    return r;
  endfunction

  logic s1_valid;
  logic s2_valid;
  logic s1_adv;
  logic s2_adv;
  logic s2_load;
  logic s3_ready;

  s1_t [LANES-1:0] s1_d;
  s1_t [LANES-1:0] s1_q;
  s2_t [LANES-1:0] s2_d;
  s2_t [LANES-1:0] s2_q;
  s3_t [LANES-1:0] s3_d;
  s3_t [LANES-1:0] s3_q;

  assign s3_ready = !out_valid || out_ready;
  assign s2_adv   = s2_valid && s3_ready;
  assign s2_load  = !s2_valid || s2_adv;
  assign s1_adv   = s1_valid && s2_load;
  assign in_ready = !s1_valid || s1_adv;

  // per-lane datapath for all three stages
  always_comb begin
    s1_d = '0;
    s2_d = '0;
    s3_d = '0;
    for (int i = 0; i < LANES; i++) begin
      s1_d[i] = align(lane_en[i], sign_a[i], sign_b[i],
                      exp_a[i*EXP_W +: EXP_W],
                      exp_b[i*EXP_W +: EXP_W],
                      mant_a[i*MANT_W +: MANT_W],
                      mant_b[i*MANT_W +: MANT_W]);
      s2_d[i] = add(s1_q[i]);
      s3_d[i] = norm(s2_q[i]);
    end
  end

  // stage 1: align register, loads when empty or draining
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  // stage 2: add register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_q     <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_q <= s2_d;
    end
  end

  // stage 3: normalised output register, held under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      s3_q      <= '0;
    end else if (s3_ready) begin
      out_valid <= s2_valid;
      if (s2_valid) s3_q <= s3_d;
    end
  end

  // unpack output register into lane-packed ports
  always_comb begin
    sign_o = '0;
    exp_o  = '0;
    mant_o = '0;
    zero_o = '0;
`ifdef MANT_ALIGN_PIPE_STICKY_EN
    sticky_o = '0;
`endif
    for (int i = 0; i < LANES; i++) begin
      sign_o[i]           = s3_q[i].sign;
      exp_o[i*XW +: XW]   = s3_q[i].exp;
      mant_o[i*AW +: AW]  = s3_q[i].mant;
      zero_o[i]           = s3_q[i].zero;
`ifdef MANT_ALIGN_PIPE_STICKY_EN
      sticky_o[i]         = s3_q[i].stk;
`endif
    end
  end

endmodule

// File: tb/tb_mant_align_pipe.sv
// tb_mant_align_pipe: directed checks of mant_align_pipe.
// Sticky checks enabled with MANT_ALIGN_PIPE_STICKY_EN.
module tb_mant_align_pipe;

  localparam int LANES  = 4;
  localparam int MANT_W = 14;
  localparam int EXP_W  = 5;
  localparam int G      = 3;
  localparam int XW     = EXP_W + 2;
  localparam int MW     = MANT_W + G;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES-1:0]        lane_en;
  logic [LANES-1:0]        sign_a;
  logic [LANES-1:0]        sign_b;
  logic [LANES*EXP_W-1:0]  exp_a;
  logic [LANES*EXP_W-1:0]  exp_b;
  logic [LANES*MANT_W-1:0] mant_a;
  logic [LANES*MANT_W-1:0] mant_b;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES-1:0]        sign_o;
  logic [LANES*XW-1:0]     exp_o;
  logic [LANES*MW-1:0]     mant_o;
  logic [LANES-1:0]        zero_o;
`ifdef MANT_ALIGN_PIPE_STICKY_EN
  logic [LANES-1:0]        sticky_o;
`endif

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mant_align_pipe #(
    .LANES(LANES), .MANT_W(MANT_W), .EXP_W(EXP_W), .G(G)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .lane_en(lane_en),
    .sign_a(sign_a),
    .sign_b(sign_b),
    .exp_a(exp_a),
    .exp_b(exp_b),
    .mant_a(mant_a),
    .mant_b(mant_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sign_o(sign_o),
    .exp_o(exp_o),
    .mant_o(mant_o),
    .zero_o(zero_o)
`ifdef MANT_ALIGN_PIPE_STICKY_EN
    ,
    .sticky_o(sticky_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      failed++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic check_lane(input string tag, input int l,
                            input logic s, input int e,
                            input int m, input logic z);
    chk({tag, ".sign"}, 32'(sign_o[l]), 32'(s));
    chk({tag, ".exp"},  32'(exp_o[l*XW +: XW]), e);
    chk({tag, ".mant"}, 32'(mant_o[l*MW +: MW]), m);
    chk({tag, ".zero"}, 32'(zero_o[l]), 32'(z));
  endtask

  task automatic clear_ops();
    lane_en = '0;
    sign_a  = '0;
    sign_b  = '0;
    exp_a   = '0;
    exp_b   = '0;
    mant_a  = '0;
    mant_b  = '0;
  endtask

  task automatic set_lane(input int l, input logic en,
                          input logic sa, input int ea, input int ma,
                          input logic sb, input int eb, input int mb);
    lane_en[l]                  = en;
    sign_a[l]                   = sa;
    sign_b[l]                   = sb;
    exp_a[l*EXP_W +: EXP_W]     = EXP_W'(ea);
    exp_b[l*EXP_W +: EXP_W]     = EXP_W'(eb);
    mant_a[l*MANT_W +: MANT_W]  = MANT_W'(ma);
    mant_b[l*MANT_W +: MANT_W]  = MANT_W'(mb);
  endtask

  task automatic load_a();
    set_lane(0, 1'b1, 1'b0, 3, 'h2000, 1'b0, 3, 'h2000);
    set_lane(1, 1'b1, 1'b0, 5, 'h2000, 1'b0, 2, 'h2000);
    set_lane(2, 1'b1, 1'b0, 4, 'h2000, 1'b1, 4, 'h3000);
    set_lane(3, 1'b1, 1'b0, 7, 'h2A00, 1'b1, 7, 'h2A00);
  endtask

  task automatic load_b();
    set_lane(0, 1'b1, 1'b0, 30, 'h2000, 1'b0, 0, 'h3FFF);
    set_lane(1, 1'b1, 1'b0, 20, 'h3001, 1'b1, 20, 'h3001);
    set_lane(2, 1'b1, 1'b0, 0, 'h2000, 1'b1, 1, 'h2000);
    set_lane(3, 1'b0, 1'b1, 9, 'h3000, 1'b1, 1, 'h2000);
  endtask

  task automatic load_p(input int k);
    clear_ops();
    set_lane(0, 1'b1, 1'b0, k, 'h2000, 1'b0, k, 'h2000);
    set_lane(1, 1'b0, 1'b1, 9, 'h3000, 1'b0, 2, 'h2100);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    clear_ops();

    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", 32'(out_valid), 0);
    chk("rst.sign", 32'(sign_o), 0);
    chk("rst.exp", 32'(exp_o), 0);
    chk("rst.mant_zero", {31'b0, (mant_o === '0)}, 1);
    chk("rst.zero", 32'(zero_o), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst.in_ready", 32'(in_ready), 1);
    chk("post_rst.out_valid", 32'(out_valid), 0);

    load_a();
    in_valid = 1'b1;
    chk("a.in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    chk("lat.c1", 32'(out_valid), 0);
    load_b();
    chk("b.in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    chk("lat.c2", 32'(out_valid), 0);
    in_valid = 1'b0;
    clear_ops();
    @(posedge clk);
    #1;
    chk("lat.c3", 32'(out_valid), 1);
    check_lane("same_exp", 0, 1'b0, 4, 'h10000, 1'b0);
    check_lane("aligned", 1, 1'b0, 5, 'h12000, 1'b0);
    check_lane("flip", 2, 1'b1, 3, 'h10000, 1'b0);
    check_lane("cancel", 3, 1'b0, 0, 0, 1'b1);
`ifdef MANT_ALIGN_PIPE_STICKY_EN
    chk("a.sticky", 32'(sticky_o), 0);
`endif
    @(posedge clk);
    #1;
    chk("b.out_valid", 32'(out_valid), 1);
    check_lane("big_shift", 0, 1'b0, 30, 'h10000, 1'b0);
    check_lane("cancel_b", 1, 1'b0, 0, 0, 1'b1);
    check_lane("b_big", 2, 1'b1, 0, 'h10000, 1'b0);
    check_lane("disabled", 3, 1'b0, 0, 0, 1'b1);
`ifdef MANT_ALIGN_PIPE_STICKY_EN
    chk("b.sticky", 32'(sticky_o), 32'h1);
`endif
    @(posedge clk);
    #1;
    chk("drained.out_valid", 32'(out_valid), 0);

    out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      load_p(k);
      in_valid = 1'b1;
      chk($sformatf("bp.accept%0d", k), 32'(in_ready), 1);
      @(posedge clk);
      #1;
    end
    load_p(4);
    chk("bp.full", 32'(in_ready), 0);
    chk("bp.out_valid", 32'(out_valid), 1);
    check_lane("bp.first", 0, 1'b0, 2, 'h10000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("bp.still_full", 32'(in_ready), 0);
    chk("bp.hold_valid", 32'(out_valid), 1);
    check_lane("bp.stable", 0, 1'b0, 2, 'h10000, 1'b0);
    out_ready = 1'b1;
    #1;
    chk("bp.release_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear_ops();
    for (int k = 2; k <= 4; k++) begin
      chk($sformatf("drain%0d.valid", k), 32'(out_valid), 1);
      check_lane($sformatf("drain%0d", k), 0, 1'b0, k + 1,
                 'h10000, 1'b0);
      check_lane($sformatf("drain%0d.off", k), 1, 1'b0, 0, 0, 1'b1);
      @(posedge clk);
      #1;
    end
    chk("drain.empty", 32'(out_valid), 0);

    out_ready = 1'b0;
    load_a();
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    load_b();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear_ops();
    @(posedge clk);
    #1;
    chk("pre_rst.out_valid", 32'(out_valid), 1);
    chk("pre_rst.sign", 32'(sign_o), 32'h4);
    chk("pre_rst.zero", 32'(zero_o), 32'h8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst.out_valid", 32'(out_valid), 0);
    chk("async_rst.sign", 32'(sign_o), 0);
    chk("async_rst.exp", 32'(exp_o), 0);
    chk("async_rst.mant_zero", {31'b0, (mant_o === '0)}, 1);
    chk("async_rst.zero", 32'(zero_o), 0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("flushed.out_valid", 32'(out_valid), 0);
    chk("flushed.in_ready", 32'(in_ready), 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
